axi_burst_addr_gen: RTL and testbench

- Parametrised AXI4 burst address generator.
- Accepts one AW or AR command (id, addr, len, size, burst) per handshake and emits one beat descriptor per transfer: address, beat index, byte-lane offset, last and error flags.
- Sits between the slave-side address-channel decode and a memory or register backend, so the backend never computes FIXED/INCR/WRAP addresses itself.
- Illegal commands are flagged per beat but still produce len+1 beats, so W/R beat counts stay matched.

---
 rtl/axi_burst_addr_gen_pkg.sv | 83 ++++++++
 rtl/axi_burst_addr_gen_if.sv | 46 ++++
 rtl/axi_burst_addr_gen_next_addr.sv | 36 +++
 rtl/axi_burst_addr_gen.sv | 148 ++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen_pkg
// Purpose  : AXI4 burst/size encodings, beat descriptor type and the
//            legality / address-span helpers shared by the burst generator.
// Revision : 1.0 - initial release
// ============================================================================
package axi_burst_addr_gen_pkg;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10,
      AXI_BURST_RSVD  = 2'b11
   } axi_burst_t;

   typedef enum logic [2:0] {
      AXI_SIZE_1B   = 3'd0,
      AXI_SIZE_2B   = 3'd1,
      AXI_SIZE_4B   = 3'd2,
      AXI_SIZE_8B   = 3'd3,
      AXI_SIZE_16B  = 3'd4,
      AXI_SIZE_32B  = 3'd5,
      AXI_SIZE_64B  = 3'd6,
      AXI_SIZE_128B = 3'd7
   } axi_size_t;

   localparam int AXI_4KB_BOUNDARY = 4096;

   // Widest fields any instance can carry; narrower instances zero-extend.
   typedef struct packed {
      logic [63:0] addr;
      logic [15:0] idx;
      logic [6:0]  lane;
      logic        last;
      logic        err;
   } axi_beat_t;

   function automatic logic [31:0] get_bytes_from_size(input logic [2:0] size);
      return 32'd1 << size;
   endfunction

   function automatic int get_strobe_width(input int data_width);
      return data_width / 8;
   endfunction

   function automatic logic is_legal_wrap_len(input logic [15:0] len);
      return (len == 16'd1) || (len == 16'd3) || (len == 16'd7) || (len == 16'd15);
   endfunction

   // Total bytes covered by the burst; 32 bits keeps 128 B * 65536 beats exact.
   function automatic logic [31:0] get_wrap_bytes(input logic [2:0] size, input logic [15:0] len);
      return get_bytes_from_size(size) * ({16'd0, len} + 32'd1);
   endfunction

   // Only the low 12 address bits matter: alignment (<= 128 B) and the 4 KB page.
   function automatic logic cmd_is_legal(input logic [1:0]  burst,
                                         input logic [2:0]  size,
                                         input logic [15:0] len,
                                         input logic [11:0] addr_lo,
                                         input int          data_width,
                                         input logic        check_4kb);
      logic [31:0] bytes;
      logic [31:0] span;
      logic [11:0] mask;
      logic        legal;
      bytes = get_bytes_from_size(size);
      mask  = bytes[11:0] - 12'd1;
      span  = {20'd0, addr_lo & ~mask} + get_wrap_bytes(size, len);
      legal = 1'b1;
      if (burst == AXI_BURST_RSVD)
         legal = 1'b0;
      if (bytes > 32'(get_strobe_width(data_width)))
         legal = 1'b0;
      if ((burst == AXI_BURST_WRAP) && (!is_legal_wrap_len(len) || ((addr_lo & mask) != 12'd0)))
         legal = 1'b0;
      if (check_4kb && (burst == AXI_BURST_INCR) && (span > 32'(AXI_4KB_BOUNDARY)))
         legal = 1'b0;
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen_if
// Purpose  : Command and beat-descriptor channels of the burst generator.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_burst_addr_gen_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int ID_WIDTH   = 4
);
   // A 8-bit bus has a single lane; keep the lane field one bit wide.
   localparam int LANE_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic [2:0]            cmd_size;
   logic [1:0]            cmd_burst;

   logic                  beat_valid;
   logic                  beat_ready;
   logic [ID_WIDTH-1:0]   beat_id;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic [LEN_WIDTH-1:0]  beat_idx;
   logic [LANE_WIDTH-1:0] beat_lane;
   logic                  beat_last;
   logic                  beat_err;
   logic                  busy;

   modport slave (
      input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
      output cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_lane,
             beat_last, beat_err, busy
   );

   modport master (
      output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
      input  cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_lane,
             beat_last, beat_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/axi_burst_addr_gen_next_addr.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_next_addr
// Purpose  : Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_next_addr
   import axi_burst_addr_gen_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] cur_addr,
   input  logic [2:0]            size,
   input  logic [1:0]            burst,
   input  logic [ADDR_WIDTH-1:0] wrap_lower,
   input  logic [ADDR_WIDTH-1:0] wrap_upper,
   output logic [ADDR_WIDTH-1:0] next_addr
);
   logic [ADDR_WIDTH-1:0] w_bytes;
   logic [ADDR_WIDTH-1:0] w_incr;

   // Aligning before the add makes an unaligned first beat land on the next boundary.
   assign w_bytes = ADDR_WIDTH'(get_bytes_from_size(size));
   assign w_incr  = (cur_addr & ~(w_bytes - ADDR_WIDTH'(1))) + w_bytes;

   // Select the successor address by burst type.
   always_comb begin
      next_addr = cur_addr;
      case (burst)
         AXI_BURST_INCR: next_addr = w_incr;
         AXI_BURST_WRAP: next_addr = (w_incr == wrap_upper) ? wrap_lower : w_incr;
         default:        next_addr = cur_addr;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_addr_gen
// Purpose  : Turns one AXI4 AW/AR command into len+1 beat descriptors
//            (address, index, lane, last, error).
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
   import axi_burst_addr_gen_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LEN_WIDTH      = 8,
   parameter int ID_WIDTH       = 4,
   parameter int BOUNDARY_CHECK = 1
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   axi_burst_addr_gen_if.slave bus
);
   localparam int         c_lane_width = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
   localparam logic [2:0] c_max_size   = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_idx;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_wrap_lower;
   logic [ADDR_WIDTH-1:0] r_wrap_upper;

   logic                  w_last;
   logic                  w_beat_hs;
   logic                  w_cmd_ready;
   logic                  w_cmd_hs;
   logic                  w_legal;
   logic [2:0]            w_size_cl;
   logic [ADDR_WIDTH-1:0] w_wrap_bytes;
   logic [ADDR_WIDTH-1:0] w_wrap_lower;
   logic [ADDR_WIDTH-1:0] w_next_addr;

   assign w_last    = (r_idx == r_len);
   assign w_beat_hs = (r_state == ST_BURST) && bus.beat_ready;
   assign w_cmd_hs  = bus.cmd_valid && w_cmd_ready;

   // Legality is resolved on the raw size; address math only ever sees a clamped size.
   assign w_legal      = cmd_is_legal(bus.cmd_burst, bus.cmd_size, 16'(bus.cmd_len),
                                      bus.cmd_addr[11:0], DATA_WIDTH, BOUNDARY_CHECK != 0);
   assign w_size_cl    = (bus.cmd_size > c_max_size) ? c_max_size : bus.cmd_size;
   assign w_wrap_bytes = ADDR_WIDTH'(get_wrap_bytes(w_size_cl, 16'(bus.cmd_len)));
   assign w_wrap_lower = bus.cmd_addr & ~(w_wrap_bytes - ADDR_WIDTH'(1));

   axi_burst_next_addr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_next_addr (
      .cur_addr   (r_addr),
      .size       (r_size),
      .burst      (r_burst),
      .wrap_lower (r_wrap_lower),
      .wrap_upper (r_wrap_upper),
      .next_addr  (w_next_addr)
   );

   // State register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next state and handshake outputs; the last-beat handshake can accept the next command.
   always_comb begin
      w_state_nxt    = r_state;
      w_cmd_ready    = 1'b0;
      bus.beat_valid = 1'b0;
      bus.busy       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cmd_ready = 1'b1;
            if (bus.cmd_valid)
               w_state_nxt = ST_BURST;
         end
         ST_BURST: begin
            bus.beat_valid = 1'b1;
            bus.busy       = 1'b1;
            w_cmd_ready    = w_beat_hs && w_last;
            if (w_beat_hs && w_last)
               w_state_nxt = bus.cmd_valid ? ST_BURST : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Burst context: load on command accept, step on each non-final beat handshake.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_id         <= '0;
         r_addr       <= '0;
         r_idx        <= '0;
         r_len        <= '0;
         r_size       <= '0;
         r_burst      <= '0;
         r_err        <= 1'b0;
         r_wrap_lower <= '0;
         r_wrap_upper <= '0;
      end else if (w_cmd_hs) begin
         r_id         <= bus.cmd_id;
         r_addr       <= bus.cmd_addr;
         r_idx        <= '0;
         r_len        <= bus.cmd_len;
         r_size       <= w_size_cl;
         // An illegal command degrades to FIXED so every beat repeats cmd_addr.
         r_burst      <= w_legal ? bus.cmd_burst : AXI_BURST_FIXED;
         r_err        <= !w_legal;
         r_wrap_lower <= w_wrap_lower;
         r_wrap_upper <= w_wrap_lower + w_wrap_bytes;
      end else if (w_beat_hs && !w_last) begin
         r_addr <= w_next_addr;
         r_idx  <= r_idx + LEN_WIDTH'(1);
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.beat_id   = r_id;
   assign bus.beat_addr = r_addr;
   assign bus.beat_idx  = r_idx;
   assign bus.beat_last = (r_state == ST_BURST) && w_last;
   assign bus.beat_err  = r_err;

   generate
      if (DATA_WIDTH > 8) begin : g_lane_multi
         assign bus.beat_lane = r_addr[c_lane_width-1:0];
      end else begin : g_lane_single
         assign bus.beat_lane = 1'b0;
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_addr_gen
// Purpose  : Self-checking bench for axi_burst_addr_gen against a beat-list
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_addr_gen;
   import axi_burst_addr_gen_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LW    = 8;
   localparam int IW    = 4;
   localparam int BYTES = DW / 8;

   logic ACLK = 1'b0;
   logic ARESETN;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low

   axi_beat_t     exp_q[$];
   logic [IW-1:0] exp_id_q[$];
   logic          stall_pending = 1'b0;
   logic [AW-1:0] stall_addr;
   logic [LW-1:0] stall_idx;

   axi_burst_addr_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

   axi_burst_addr_gen #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW), .BOUNDARY_CHECK(1)
   ) u_dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: expand a command into its beat list straight from the burst rules.
   function automatic void model_push(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                      input logic [LW-1:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      longint unsigned b, w, aligned, lower, a, nbeats;
      bit err;
      axi_beat_t beat;
      b       = 64'd1 << size;
      nbeats  = longint'(len) + 1;
      w       = b * nbeats;
      aligned = longint'(addr) - (longint'(addr) % b);
      lower   = longint'(addr) - (longint'(addr) % w);
      err = (burst == 2'b11) || (b > BYTES) ||
            (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
            (burst == 2'b10 && (longint'(addr) % b) != 0) ||
            (burst == 2'b01 && ((aligned % 4096) + nbeats * b) > 4096);
      for (longint unsigned n = 0; n < nbeats; n++) begin
         if (err || burst == 2'b00)
            a = longint'(addr);
         else if (burst == 2'b01)
            a = (n == 0) ? longint'(addr) : (aligned + n * b) % (64'd1 << AW);
         else
            a = lower + ((longint'(addr) - lower + n * b) % w);
         beat      = '0;
         beat.addr = a;
         beat.idx  = 16'(n);
         beat.lane = 7'(a % BYTES);
         beat.last = (n == nbeats - 1);
         beat.err  = err;
         exp_q.push_back(beat);
         exp_id_q.push_back(id);
      end
   endfunction

   // Downstream ready generator.
   initial begin
      bus.beat_ready = 1'b1;
      forever begin
         @(posedge ACLK); #1;
         case (ready_mode)
            0:       bus.beat_ready = 1'b1;
            1:       bus.beat_ready = ($urandom_range(0, 3) != 0);
            default: bus.beat_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compare every cycle against the expected beat list.
   initial begin
      axi_beat_t e;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            chk_eq("rst_cmd_ready", bus.cmd_ready, 1);
            chk_eq("rst_beat_valid", bus.beat_valid, 0);
            exp_q.delete();
            exp_id_q.delete();
            stall_pending = 1'b0;
         end else begin
            chk_eq("beat_valid", bus.beat_valid, exp_q.size() != 0);
            chk_eq("busy", bus.busy, exp_q.size() != 0);
            chk_eq("cmd_ready", bus.cmd_ready,
                   (exp_q.size() == 0) || (bus.beat_ready && exp_q.size() == 1));
            if (stall_pending) begin
               chk_eq("stall_addr", bus.beat_addr, stall_addr);
               chk_eq("stall_idx", bus.beat_idx, stall_idx);
            end
            if (bus.beat_valid && exp_q.size() != 0) begin
               e = exp_q[0];
               chk_eq("beat_addr", bus.beat_addr, e.addr);
               chk_eq("beat_idx", bus.beat_idx, e.idx);
               chk_eq("beat_lane", bus.beat_lane, e.lane);
               chk_eq("beat_last", bus.beat_last, e.last);
               chk_eq("beat_err", bus.beat_err, e.err);
               chk_eq("beat_id", bus.beat_id, exp_id_q[0]);
               if (bus.beat_ready) begin
                  void'(exp_q.pop_front());
                  void'(exp_id_q.pop_front());
               end
            end
            stall_pending = bus.beat_valid && !bus.beat_ready;
            stall_addr    = bus.beat_addr;
            stall_idx     = bus.beat_idx;
            if (bus.cmd_valid && bus.cmd_ready)
               model_push(bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst);
         end
      end
   end

   // Present a command and hold it until it is accepted.
   task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [LW-1:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit accepted = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_id    = id;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.cmd_size  = size;
      bus.cmd_burst = burst;
      for (int i = 0; i < 2000; i++) begin
         @(negedge ACLK);
         if (bus.cmd_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      @(posedge ACLK); #1;
      bus.cmd_valid = 1'b0;
      if (!accepted)
         chk_eq("cmd_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge ACLK);
         if (!bus.busy && exp_q.size() == 0) begin
            idle = 1'b1;
            break;
         end
      end
      @(posedge ACLK); #1;
      if (!idle)
         chk_eq("drain_timeout", 0, 1);
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [2:0]    sz;
      logic [1:0]    bt;
      bit            found;
      ARESETN       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_id    = '0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.cmd_size  = '0;
      bus.cmd_burst = '0;
      #1;
      chk_eq("reset_cmd_ready", bus.cmd_ready, 1);
      chk_eq("reset_beat_valid", bus.beat_valid, 0);
      chk_eq("reset_busy", bus.busy, 0);
      chk_eq("reset_beat_addr", bus.beat_addr, 0);
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      @(posedge ACLK); #1;

      // Directed bursts, issued back to back.
      issue(4'h1, 32'h1004, 8'd3, 3'd2, 2'b01);
      issue(4'h2, 32'h1003, 8'd1, 3'd2, 2'b01);
      issue(4'h3, 32'h2008, 8'd3, 3'd2, 2'b10);
      issue(4'h4, 32'h0030, 8'd2, 3'd2, 2'b00);
      issue(4'h5, 32'h0040, 8'd2, 3'd2, 2'b10);
      issue(4'h6, 32'h0FF8, 8'd3, 3'd2, 2'b01);
      issue(4'h7, 32'h0100, 8'd1, 3'd3, 2'b01);
      issue(4'h8, 32'h0200, 8'd1, 3'd2, 2'b11);
      issue(4'h9, 32'h0300, 8'd0, 3'd1, 2'b01);
      wait_idle();

      // Backpressure in the middle of a burst.
      issue(4'hA, 32'h0500, 8'd7, 3'd2, 2'b01);
      repeat (2) @(posedge ACLK);
      ready_mode = 2;
      repeat (5) @(posedge ACLK);
      ready_mode = 0;
      wait_idle();

      // Reset at beat 2 of a len-7 INCR.
      issue(4'hB, 32'h0600, 8'd7, 3'd2, 2'b01);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge ACLK); #1;
         if (bus.beat_valid && bus.beat_idx == 8'd2) begin
            found = 1'b1;
            break;
         end
      end
      chk_eq("reached_beat2", found, 1);
      ARESETN = 1'b0;
      #1;
      chk_eq("midrst_beat_valid", bus.beat_valid, 0);
      chk_eq("midrst_cmd_ready", bus.cmd_ready, 1);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      issue(4'hC, 32'h0700, 8'd3, 3'd2, 2'b01);
      wait_idle();

      // Randomised commands with random backpressure.
      for (int n = 0; n < 80; n++) begin
         ready_mode = $urandom_range(0, 1);
         a  = $urandom;
         if ($urandom_range(0, 2) == 0)
            a = (a & 32'hFFFF_F000) | 32'h0000_0F00 | (a & 32'h0000_00FF);
         sz = 3'($urandom_range(0, 3));
         bt = 2'($urandom_range(0, 3));
         if (bt == 2'b10 && $urandom_range(0, 3) != 0)
            a = a & ~((32'd1 << sz) - 32'd1);
         issue(4'($urandom), a, 8'($urandom_range(0, 15)), sz, bt);
         repeat ($urandom_range(0, 2)) begin
            @(posedge ACLK); #1;
         end
      end
      ready_mode = 0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
